// File: rtl/tl_ad_pkg.sv
// Shared widths, field offsets and packed payload types for the TileLink-UL A/D buffer.
// Build option TL_AD_BUFFER_PIPE_EN is consumed by tl_ad_fifo; nothing here depends on it.
package tl_ad_pkg;

  localparam int A_W = 117;
  localparam int D_W = 79;

  localparam int A_CORRUPT_LSB = 0;
  localparam int A_DATA_LSB    = 1;
  localparam int A_MASK_LSB    = 65;
  localparam int A_ADDR_LSB    = 73;
  localparam int A_SOURCE_LSB  = 104;
  localparam int A_SIZE_LSB    = 107;
  localparam int A_PARAM_LSB   = 111;
  localparam int A_OPCODE_LSB  = 114;

  localparam int D_CORRUPT_LSB = 0;
  localparam int D_DATA_LSB    = 1;
  localparam int D_DENIED_LSB  = 65;
  localparam int D_SINK_LSB    = 66;
  localparam int D_SOURCE_LSB  = 67;
  localparam int D_SIZE_LSB    = 70;
  localparam int D_PARAM_LSB   = 74;
  localparam int D_OPCODE_LSB  = 76;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic [30:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic        sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_ad_fifo.sv
// Registered circular-buffer FIFO used for each TileLink channel of tl_ad_buffer.
// Define TL_AD_BUFFER_PIPE_EN to let a same-cycle dequeue open the enqueue side when full.
module tl_ad_fifo
  import tl_ad_pkg::*;
#(
  parameter int WIDTH = A_W,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Handshakes are forced low while reset is held so nothing moves during reset.
  assign deq_valid = reset && !empty;
  assign deq_fire  = deq_valid && deq_ready;
`ifdef TL_AD_BUFFER_PIPE_EN
  assign enq_ready = reset && (!full || deq_fire);
`else
  assign enq_ready = reset && !full;
`endif
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_bits  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[wr_ptr] <= enq_bits;
  end

endmodule

// File: rtl/tl_ad_buffer.sv
// Registered TileLink-UL A/D buffer with a downstream in-flight request limiter.
// Build option TL_AD_BUFFER_PIPE_EN (see tl_ad_fifo) enables full-rate enqueue when full.
module tl_ad_buffer
  import tl_ad_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           auto_in_a_valid,
  output logic           auto_in_a_ready,
  input  logic [A_W-1:0] auto_in_a_bits,
  output logic           auto_out_a_valid,
  input  logic           auto_out_a_ready,
  output logic [A_W-1:0] auto_out_a_bits,
  input  logic           auto_out_d_valid,
  output logic           auto_out_d_ready,
  input  logic [D_W-1:0] auto_out_d_bits,
  output logic           auto_in_d_valid,
  input  logic           auto_in_d_ready,
  output logic [D_W-1:0] auto_in_d_bits,
  output logic [7:0]     inflight
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_INFLIGHT);

  logic a_deq_valid;
  logic a_deq_ready;
  logic can_issue;
  logic a_fire;
  logic d_fire;

  // Uses the registered count, so a D return only releases A on the following cycle.
  assign can_issue        = (inflight < MAX_CNT);
  assign auto_out_a_valid = a_deq_valid && can_issue;
  assign a_deq_ready      = auto_out_a_ready && can_issue;
  assign a_fire           = auto_out_a_valid && auto_out_a_ready;
  assign d_fire           = auto_out_d_valid && auto_out_d_ready;

  tl_ad_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_bits  (auto_in_a_bits),
    .deq_valid (a_deq_valid),
    .deq_ready (a_deq_ready),
    .deq_bits  (auto_out_a_bits)
  );

  tl_ad_fifo #(.WIDTH(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (auto_out_d_bits),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (auto_in_d_bits)
  );

  // A D beat with no matching outstanding request leaves the count pinned at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight <= '0;
    end else if (a_fire && !d_fire) begin
      inflight <= inflight + 8'd1;
    end else if (d_fire && !a_fire && (inflight != '0)) begin
      inflight <= inflight - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && d_fire && !a_fire) begin
      assert (inflight != '0);
    end
  end

endmodule

// File: tb/tb_tl_ad_buffer.sv
// Directed self-checking bench for tl_ad_buffer with DEPTH=2, MAX_INFLIGHT=2.
// Expectations follow TL_AD_BUFFER_PIPE_EN when the bench is built with it.
module tb_tl_ad_buffer;
  import tl_ad_pkg::*;

`ifdef TL_AD_BUFFER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           auto_in_a_valid;
  logic           auto_in_a_ready;
  tl_a_t          auto_in_a_bits;
  logic           auto_out_a_valid;
  logic           auto_out_a_ready;
  logic [A_W-1:0] auto_out_a_bits;
  logic           auto_out_d_valid;
  logic           auto_out_d_ready;
  tl_d_t          auto_out_d_bits;
  logic           auto_in_d_valid;
  logic           auto_in_d_ready;
  logic [D_W-1:0] auto_in_d_bits;
  logic [7:0]     inflight;

  int checks = 0;
  int passed = 0;

  tl_ad_buffer #(.DEPTH(2), .MAX_INFLIGHT(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .auto_in_a_valid  (auto_in_a_valid),
    .auto_in_a_ready  (auto_in_a_ready),
    .auto_in_a_bits   (auto_in_a_bits),
    .auto_out_a_valid (auto_out_a_valid),
    .auto_out_a_ready (auto_out_a_ready),
    .auto_out_a_bits  (auto_out_a_bits),
    .auto_out_d_valid (auto_out_d_valid),
    .auto_out_d_ready (auto_out_d_ready),
    .auto_out_d_bits  (auto_out_d_bits),
    .auto_in_d_valid  (auto_in_d_valid),
    .auto_in_d_ready  (auto_in_d_ready),
    .auto_in_d_bits   (auto_in_d_bits),
    .inflight         (inflight)
  );

  always #5 clock = ~clock;

  function automatic tl_a_t mkA(input logic [2:0] src, input logic [30:0] addr, input logic [63:0] data);
    tl_a_t a;
    a.opcode  = 3'd0;
    a.param   = 3'd0;
    a.size    = 4'd3;
    a.source  = src;
    a.address = addr;
    a.mask    = 8'hFF;
    a.data    = data;
    a.corrupt = 1'b0;
    return a;
  endfunction

  function automatic tl_d_t mkD(input logic [2:0] src, input logic [63:0] data);
    tl_d_t d;
    d.opcode  = 3'd1;
    d.param   = 2'd0;
    d.size    = 4'd3;
    d.source  = src;
    d.sink    = 1'b0;
    d.denied  = 1'b0;
    d.data    = data;
    d.corrupt = 1'b0;
    return d;
  endfunction

  function automatic tl_a_t mkB(input int i);
    return mkA(3'(i), 31'h1000 + 31'(i * 8), 64'(i) * 64'h0101_0101_0101_0101);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic a_v, input tl_a_t a_b, input logic oa_r,
                               input logic od_v, input tl_d_t d_b, input logic id_r);
    auto_in_a_valid  = a_v;
    auto_in_a_bits   = a_b;
    auto_out_a_ready = oa_r;
    auto_out_d_valid = od_v;
    auto_out_d_bits  = d_b;
    auto_in_d_ready  = id_r;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tl_a_t a1, a2, a3;
    tl_d_t d1, d2, d3;
    a1 = mkA(3'd3, 31'h40, 64'h1111_2222_3333_4444);
    a2 = mkA(3'd1, 31'h80, 64'h5555_6666_7777_8888);
    a3 = mkA(3'd2, 31'hC0, 64'h9999_AAAA_BBBB_CCCC);
    d1 = mkD(3'd3, 64'hAAAA_AAAA_AAAA_AAAA);
    d2 = mkD(3'd1, 64'h5555_5555_5555_5555);
    d3 = mkD(3'd2, 64'h0123_4567_89AB_CDEF);

    // Reset held for three edges with upstream A valid asserted.
    applyStimulus(1'b1, mkA(3'd7, 31'h7FF0, 64'hDEAD), 1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_a_ready", 128'(auto_in_a_ready), 128'(0));
    checkOutput("rst_out_a_valid", 128'(auto_out_a_valid), 128'(0));
    checkOutput("rst_out_d_ready", 128'(auto_out_d_ready), 128'(0));
    checkOutput("rst_in_d_valid", 128'(auto_in_d_valid), 128'(0));
    checkOutput("rst_inflight", 128'(inflight), 128'(0));

    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("rel_in_a_ready", 128'(auto_in_a_ready), 128'(1));
    checkOutput("rel_out_d_ready", 128'(auto_out_d_ready), 128'(1));
    checkOutput("rel_out_a_valid", 128'(auto_out_a_valid), 128'(0));

    // Latency and capacity.
    nextCycle(); applyStimulus(1'b1, a1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("lat_same_cycle_valid", 128'(auto_out_a_valid), 128'(0));
    nextCycle(); applyStimulus(1'b1, a2, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("lat_next_valid", 128'(auto_out_a_valid), 128'(1));
    checkOutput("lat_payload", 128'(auto_out_a_bits), 128'(a1));
    checkOutput("lat_in_ready_one", 128'(auto_in_a_ready), 128'(1));
    nextCycle(); applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("full_in_ready", 128'(auto_in_a_ready), 128'(0));
    checkOutput("full_head", 128'(auto_out_a_bits), 128'(a1));

    // In-flight cap of two.
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("cap_c0_valid", 128'(auto_out_a_valid), 128'(1));
    checkOutput("cap_c0_bits", 128'(auto_out_a_bits), 128'(a1));
    nextCycle(); applyStimulus(1'b1, a3, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("cap_c1_bits", 128'(auto_out_a_bits), 128'(a2));
    checkOutput("cap_c1_inflight", 128'(inflight), 128'(1));
    checkOutput("cap_c1_in_ready", 128'(auto_in_a_ready), 128'(1));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clock);
    checkOutput("cap_c2_inflight", 128'(inflight), 128'(2));
    checkOutput("cap_c2_blocked", 128'(auto_out_a_valid), 128'(0));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, d1, 1'b0);
    @(negedge clock);
    checkOutput("cap_d_same_cycle_blocked", 128'(auto_out_a_valid), 128'(0));
    checkOutput("cap_d_out_ready", 128'(auto_out_d_ready), 128'(1));
    checkOutput("cap_d_inflight", 128'(inflight), 128'(2));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, d2, 1'b0);
    @(negedge clock);
    checkOutput("cap_release_inflight", 128'(inflight), 128'(1));
    checkOutput("cap_release_valid", 128'(auto_out_a_valid), 128'(1));
    checkOutput("cap_release_bits", 128'(auto_out_a_bits), 128'(a3));
    checkOutput("d_first_valid", 128'(auto_in_d_valid), 128'(1));
    checkOutput("d_first_bits", 128'(auto_in_d_bits), 128'(d1));

    // D backpressure: two buffered, third held off.
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, d3, 1'b0);
    @(negedge clock);
    checkOutput("simul_inflight", 128'(inflight), 128'(1));
    checkOutput("d_full_out_ready", 128'(auto_out_d_ready), 128'(0));
    checkOutput("a_empty_valid", 128'(auto_out_a_valid), 128'(0));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b0, d3, 1'b1);
    @(negedge clock);
    checkOutput("d_drain0_bits", 128'(auto_in_d_bits), 128'(d1));
    checkOutput("d_full_deq_ready", 128'(auto_out_d_ready), 128'(PIPE));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, d3, 1'b1);
    @(negedge clock);
    checkOutput("d_drain1_bits", 128'(auto_in_d_bits), 128'(d2));
    checkOutput("d_drain1_out_ready", 128'(auto_out_d_ready), 128'(1));
    checkOutput("d_drain1_inflight", 128'(inflight), 128'(1));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clock);
    checkOutput("d_drain2_valid", 128'(auto_in_d_valid), 128'(1));
    checkOutput("d_drain2_bits", 128'(auto_in_d_bits), 128'(d3));
    checkOutput("d_drain2_inflight", 128'(inflight), 128'(0));
    nextCycle();
    @(negedge clock);
    checkOutput("d_empty_valid", 128'(auto_in_d_valid), 128'(0));

    // Steady enqueue+dequeue at count 1, wrapping the pointers several times.
    nextCycle(); applyStimulus(1'b1, mkB(0), 1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      applyStimulus(1'b1, mkB(i), 1'b1, (i > 1), mkD(3'(i), 64'(i)), 1'b1);
      @(negedge clock);
      checkOutput($sformatf("wrap_bits_%0d", i), 128'(auto_out_a_bits), 128'(mkB(i - 1)));
      checkOutput($sformatf("wrap_in_ready_%0d", i), 128'(auto_in_a_ready), 128'(1));
      checkOutput($sformatf("wrap_inflight_%0d", i), 128'(inflight), 128'((i > 1) ? 1 : 0));
    end
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, mkD(3'd0, 64'h11), 1'b1);
    @(negedge clock);
    checkOutput("wrap_last_bits", 128'(auto_out_a_bits), 128'(mkB(10)));
    checkOutput("wrap_last_inflight", 128'(inflight), 128'(1));
    nextCycle(); applyStimulus(1'b0, '0, 1'b0, 1'b1, mkD(3'd0, 64'h12), 1'b1);
    @(negedge clock);
    checkOutput("wrap_tail_inflight", 128'(inflight), 128'(1));
    checkOutput("wrap_tail_valid", 128'(auto_out_a_valid), 128'(0));
    nextCycle(); applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clock);
    checkOutput("wrap_done_inflight", 128'(inflight), 128'(0));

    // Full FIFO with a same-cycle dequeue: pipe build keeps 1 beat/cycle.
    nextCycle(); applyStimulus(1'b1, mkB(20), 1'b0, 1'b0, '0, 1'b1);
    nextCycle(); applyStimulus(1'b1, mkB(21), 1'b0, 1'b0, '0, 1'b1);
    nextCycle(); applyStimulus(1'b1, mkB(22), 1'b1, 1'b0, '0, 1'b1);
    @(negedge clock);
    checkOutput("pipe_full_in_ready", 128'(auto_in_a_ready), 128'(PIPE));
    checkOutput("pipe_p0_bits", 128'(auto_out_a_bits), 128'(mkB(20)));
    nextCycle(); applyStimulus(1'b1, PIPE ? mkB(23) : mkB(22), 1'b1, 1'b1, mkD(3'd1, 64'h21), 1'b1);
    @(negedge clock);
    checkOutput("pipe_p1_bits", 128'(auto_out_a_bits), 128'(mkB(21)));
    checkOutput("pipe_p1_in_ready", 128'(auto_in_a_ready), 128'(1));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, mkD(3'd1, 64'h22), 1'b1);
    @(negedge clock);
    checkOutput("pipe_p2_bits", 128'(auto_out_a_bits), 128'(mkB(22)));
    nextCycle(); applyStimulus(1'b0, '0, 1'b1, 1'b1, mkD(3'd1, 64'h23), 1'b1);
    @(negedge clock);
    checkOutput("pipe_p3_valid", 128'(auto_out_a_valid), 128'(PIPE));
    nextCycle(); applyStimulus(1'b0, '0, 1'b0, PIPE, mkD(3'd1, 64'h24), 1'b1);
    @(negedge clock);
    checkOutput("pipe_tail_inflight", 128'(inflight), 128'(PIPE));
    nextCycle(); applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clock);
    checkOutput("pipe_done_inflight", 128'(inflight), 128'(0));
    checkOutput("pipe_done_in_ready", 128'(auto_in_a_ready), 128'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tl_ad_buffer.md
Name: tl_ad_buffer

Overview:
- Registered TileLink-UL A/D buffer that sits directly downstream of the 1:1 TL crossbar (TLXbar_4) on the same 31-bit address, 64-bit data, 3-bit source link.
- Decouples timing with a DEPTH-entry FIFO per channel: A flows in→out, D flows out→in.
- Limits requests in flight downstream to MAX_INFLIGHT and exports the live count for debug.

Parameters:
- DEPTH, 2, entries per channel FIFO; a power of two, minimum 2.
- MAX_INFLIGHT, 8, maximum A beats accepted downstream without a D beat returned upstream; range 1..255.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (0 = in reset), sampled on the rising edge of clock.
- auto_in_a_valid  in  1  upstream A valid.
- auto_in_a_ready  out  1  upstream A ready.
- auto_in_a_bits  in  117  packed A payload {opcode[2:0], param[2:0], size[3:0], source[2:0], address[30:0], mask[7:0], data[63:0], corrupt}, MSB first.
- auto_out_a_valid  out  1  downstream A valid.
- auto_out_a_ready  in  1  downstream A ready.
- auto_out_a_bits  out  117  A payload, same packing as auto_in_a_bits.
- auto_out_d_valid  in  1  downstream D valid.
- auto_out_d_ready  out  1  downstream D ready.
- auto_out_d_bits  in  79  packed D payload {opcode[2:0], param[1:0], size[3:0], source[2:0], sink, denied, data[63:0], corrupt}, MSB first.
- auto_in_d_valid  out  1  upstream D valid.
- auto_in_d_ready  in  1  upstream D ready.
- auto_in_d_bits  out  79  D payload, same packing as auto_out_d_bits.
- inflight  out  8  current outstanding count.

Behaviour:
- Fire definition: a channel fires when valid && ready are both high on a rising edge.
- Reset (reset==0 at a clock edge):
  - FIFO read/write pointers and entry counts are cleared.
  - inflight is cleared to 0.
  - All valid and ready outputs read 0 while reset is low.
  - bits outputs are don't-care; storage is not cleared.
  - Traffic in progress when reset asserts is discarded, with no partial beats.
- Each channel FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers and a (log2(DEPTH)+1)-bit count.
  - full = (count==DEPTH); empty = (count==0).
  - Enqueue-side ready = !full; dequeue-side valid = !empty; dequeue bits = head entry, driven straight from storage.
  - Latency: an entry written at edge N is visible on the output from cycle N+1. There is no combinational in→out path on any valid, ready or bits signal.
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When full, a dequeue in the same cycle does NOT open enqueue (see the optional feature).
- Inflight limiter:
  - auto_out_a_valid = A FIFO !empty && (inflight < MAX_INFLIGHT).
  - A-FIFO dequeue happens only on auto_out_a fire.
  - inflight +1 on auto_out_a fire; -1 on auto_out_d fire.
  - Both in the same cycle: unchanged.
  - At MAX_INFLIGHT with a D fire in the same cycle: A is still blocked that cycle and is released the next cycle.
  - Decrementing at 0 is a protocol error: an assertion fires in simulation and the count saturates at 0.
- D channel: a D beat is counted at downstream acceptance, not at upstream delivery.
- Ordering: beats within each channel are strictly FIFO. There is no reordering by source.
- Payload is passed bit-exact; no field is inspected except for the counting above.

Optional Feature:
- Macro: TL_AD_BUFFER_PIPE_EN.
- Defined: enqueue ready = !full || dequeue-fire in the same cycle, on both channels. This creates a combinational ready path from the out side to the in side, and gives full throughput when the FIFO is full.
- Undefined: enqueue ready = !full only, with no combinational ready path.

Decomposition:
- Package tl_ad_pkg holds:
  - A_W=117 and D_W=79;
  - field offset localparams;
  - typedefs tl_a_t and tl_d_t as packed structs in the order above.
- One sub-module, tl_ad_fifo, parameterised by WIDTH and DEPTH, holding the pipe option. It is instantiated twice, once per channel.

Test Plan:
- Reset: hold reset=0 for 3 cycles with auto_in_a_valid=1 → all valid and ready outputs read 0, inflight=0. First cycle after release: auto_in_a_ready=1.
- Latency and capacity (DEPTH=2): send A beat source=3, address=0x40, with auto_out_a_ready=0 → auto_out_a_valid rises the next cycle with an identical payload. A second beat fills the FIFO → auto_in_a_ready=0.
- Inflight cap (MAX_INFLIGHT=2): send 3 A beats with auto_out_a_ready=1 and no D → exactly 2 fire downstream, inflight=2, third beat held. One D fire → inflight stays 2 that cycle, third A fires the next cycle.
- Simultaneous events: A out fire and D out fire in the same cycle with inflight=1 → inflight stays 1. With the FIFO at count 1, enqueue and dequeue together → count stays 1 and pointers wrap correctly over 10 beats.
- D path backpressure: auto_in_d_ready=0 while 3 D beats arrive → 2 are buffered, auto_out_d_ready=0. Release → beats are delivered in order, with data 0xAAAA…, 0x5555…, then the third.
- PIPE_EN build with the FIFO full: dequeue and enqueue in the same cycle → auto_in_a_ready=1 that cycle, sustaining 1 beat/cycle; the non-PIPE build shows a 1-cycle bubble.
